// File: rtl/mandala_pkg.sv
// Shared types and lookup tables for the mandala pattern engine.
//   mode_e        : animation mode as presented on the mode input
//   pulse_state_t : ring-pulse FSM state encoding
//   ANG_TA/ANG_TB : per-ring pair of angle bits whose XOR decides if a pixel is lit
//   TINT          : per-ring colour, three 6-bit channels {R,G,B}; the engine keeps
//                   the CBITS most significant bits of each channel
package mandala_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_ROT    = 2'd1,
      MODE_ROTCOL = 2'd2,
      MODE_PULSE  = 2'd3
   } mode_e;

   typedef logic [1:0] pulse_state_t;
   localparam pulse_state_t PS_IDLE   = 2'd0;
   localparam pulse_state_t PS_GROW   = 2'd1;
   localparam pulse_state_t PS_SHRINK = 2'd2;

   localparam logic [2:0] ANG_TA [16] = '{
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
      3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7
   };

   localparam logic [2:0] ANG_TB [16] = '{
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0,
      3'd3, 3'd5, 3'd7, 3'd1, 3'd4, 3'd6, 3'd0, 3'd2
   };

   localparam logic [17:0] TINT [16] = '{
      {6'd63, 6'd0,  6'd0 },
      {6'd63, 6'd32, 6'd0 },
      {6'd63, 6'd63, 6'd0 },
      {6'd0,  6'd63, 6'd0 },
      {6'd0,  6'd63, 6'd63},
      {6'd0,  6'd0,  6'd63},
      {6'd32, 6'd0,  6'd63},
      {6'd63, 6'd0,  6'd63},
      {6'd63, 6'd63, 6'd63},
      {6'd16, 6'd16, 6'd16},
      {6'd48, 6'd16, 6'd0 },
      {6'd0,  6'd48, 6'd16},
      {6'd16, 6'd0,  6'd48},
      {6'd40, 6'd40, 6'd8 },
      {6'd8,  6'd40, 6'd40},
      {6'd40, 6'd8,  6'd40}
   };

   // Per-frame counter increment: speed 0..7 maps to a step of 1..8.
   function automatic logic [3:0] frame_step(input logic [2:0] speed);
      return {1'b0, speed} + 4'd1;
   endfunction

endpackage

// File: rtl/mandala_anim_ctrl.sv
// Frame-rate animation state for the mandala engine: rotation counter, colour-cycle
// counter and the ring-pulse FSM. Everything moves only on frame_start, using the
// mode/speed present on that cycle, so the picture never tears mid-frame.
//   clk, rst_n   : pixel clock, synchronous active-low reset
//   frame_start  : one-cycle pulse at the start of vsync
//   mode, speed  : animation controls, only looked at on frame_start
//   rot_cnt_o    : 8-bit rotation added to the folded angle
//   base_o       : colour-cycle offset (top CBITS of the colour counter)
//   pulse_off_o  : offset added to the squared radius in pulse mode
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PS_IDLE   | not pulsing, pulse_off held at 0
// PS_GROW   | pulse_off rising by 64*(speed+1) per frame up to PULSE_MAX
// PS_SHRINK | pulse_off falling by 64*(speed+1) per frame down to 0
module mandala_anim_ctrl
   import mandala_pkg::*;
#(
   parameter int CBITS      = 2,
   parameter int RING_SHIFT = 14,
   parameter int PULSE_MAX  = 8191
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic [1:0]            mode,
   input  logic [2:0]            speed,
   output logic [7:0]            rot_cnt_o,
   output logic [CBITS-1:0]      base_o,
   output logic [RING_SHIFT-1:0] pulse_off_o
);

   // Headroom so the grow sum can be compared against PULSE_MAX before clamping.
   localparam int ACC_W = RING_SHIFT + 11;
   localparam logic [ACC_W-1:0] PMAX_W = ACC_W'(PULSE_MAX);

   logic [7:0]            rot_q, rot_d;
   logic [7:0]            col_q, col_d;
   logic [RING_SHIFT-1:0] pulse_q, pulse_d;
   pulse_state_t          state_q, state_d;

   mode_e            mode_s;
   logic [3:0]       inc;
   logic [ACC_W-1:0] step_w, pulse_w, grow_w;

   always_comb begin
      mode_s  = mode_e'(mode);
      inc     = frame_step(speed);
      step_w  = ACC_W'({inc, 6'b0});
      pulse_w = ACC_W'(pulse_q);
      grow_w  = pulse_w + step_w;
      rot_d   = rot_q;
      col_d   = col_q;
      pulse_d = pulse_q;
      state_d = state_q;
      if (frame_start) begin
         if (mode_s != MODE_STATIC) rot_d = rot_q + {4'b0, inc};
         if (mode_s == MODE_ROTCOL) col_d = col_q + {4'b0, inc};
         if (mode_s != MODE_PULSE) begin
            state_d = PS_IDLE;
            pulse_d = '0;
         end else begin
            case (state_q)
               // IDLE always holds pulse_off at 0, so leaving it takes the first
               // grow step on the same frame.
               PS_IDLE, PS_GROW: begin
                  if (grow_w >= PMAX_W) begin
                     pulse_d = PMAX_W[RING_SHIFT-1:0];
                     state_d = PS_SHRINK;
                  end else begin
                     pulse_d = grow_w[RING_SHIFT-1:0];
                     state_d = PS_GROW;
                  end
               end
               PS_SHRINK: begin
                  if (pulse_w <= step_w) begin
                     pulse_d = '0;
                     state_d = PS_GROW;
                  end else begin
                     pulse_d = pulse_q - step_w[RING_SHIFT-1:0];
                  end
               end
               default: begin
                  state_d = PS_IDLE;
                  pulse_d = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rot_q   <= '0;
         col_q   <= '0;
         pulse_q <= '0;
         state_q <= PS_IDLE;
      end else begin
         rot_q   <= rot_d;
         col_q   <= col_d;
         pulse_q <= pulse_d;
         state_q <= state_d;
      end
   end

   assign rot_cnt_o   = rot_q;
   assign base_o      = col_q[7 -: CBITS];
   assign pulse_off_o = pulse_q;

endmodule

// File: rtl/mandala_pixel_pipe.sv
// Three-stage mandala pixel pipeline for the TinyVGA tile.
//   S1: |dx|, |dy| from the pattern centre and the rotated folded angle
//   S2: saturated squared radius plus pulse offset
//   S3: ring select, angle-bit test and ring colour + colour-cycle base
// hsync/vsync/valid ride along the same three stages so colour and sync stay aligned.
//   clk, rst_n          : pixel clock, synchronous active-low reset
//   frame_start         : start-of-frame pulse, advances the animation
//   pix_valid           : display_on; rgb is forced to 0 when low
//   pix_x, pix_y        : current pixel coordinate
//   hsync_in, vsync_in  : raw syncs
//   mode, speed         : animation controls (used on frame_start only)
//   rgb                 : {R,G,B}, CBITS each
//   hsync_out, vsync_out: syncs delayed to match rgb
module mandala_pixel_pipe
   import mandala_pkg::*;
#(
   parameter int H_CENTER   = 320,
   parameter int V_CENTER   = 240,
   parameter int NUM_RINGS  = 8,
   parameter int RING_SHIFT = 14,
   parameter int CBITS      = 2,
   parameter int PULSE_MAX  = 8191
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [9:0]         pix_x,
   input  logic [9:0]         pix_y,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic [1:0]         mode,
   input  logic [2:0]         speed,
   output logic [3*CBITS-1:0] rgb,
   output logic               hsync_out,
   output logic               vsync_out
);

   localparam logic [9:0]  HC     = 10'(H_CENTER);
   localparam logic [9:0]  VC     = 10'(V_CENTER);
   localparam logic [20:0] NRINGS = 21'(NUM_RINGS);

   logic [7:0]            rot_cnt;
   logic [CBITS-1:0]      base;
   logic [RING_SHIFT-1:0] pulse_off;

   mandala_anim_ctrl #(
      .CBITS      (CBITS),
      .RING_SHIFT (RING_SHIFT),
      .PULSE_MAX  (PULSE_MAX)
   ) u_anim (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .mode        (mode),
      .speed       (speed),
      .rot_cnt_o   (rot_cnt),
      .base_o      (base),
      .pulse_off_o (pulse_off)
   );

   // Stage 1. pulse_off and base are captured with the pixel so a frame_start
   // that lands while the pixel is in flight cannot change its colour.
   logic [9:0]            dx_d, dy_d;
   logic [7:0]            ang_d;
   logic [9:0]            dx_q, dy_q;
   logic [7:0]            ang1_q;
   logic [RING_SHIFT-1:0] pulse1_q;
   logic [CBITS-1:0]      base1_q;
   logic                  v1_q, hs1_q, vs1_q;

   always_comb begin
      dx_d  = (pix_x >= HC) ? pix_x - HC : HC - pix_x;
      dy_d  = (pix_y >= VC) ? pix_y - VC : VC - pix_y;
      ang_d = (dx_d[7:0] ^ dy_d[7:0]) + rot_cnt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dx_q     <= '0;
         dy_q     <= '0;
         ang1_q   <= '0;
         pulse1_q <= '0;
         base1_q  <= '0;
         v1_q     <= 1'b0;
         hs1_q    <= 1'b0;
         vs1_q    <= 1'b0;
      end else begin
         dx_q     <= dx_d;
         dy_q     <= dy_d;
         ang1_q   <= ang_d;
         pulse1_q <= pulse_off;
         base1_q  <= base;
         v1_q     <= pix_valid;
         hs1_q    <= hsync_in;
         vs1_q    <= vsync_in;
      end
   end

   // Stage 2
   logic [19:0]      dx2, dy2, r2;
   logic [20:0]      r2_sum, rsum_d;
   logic [20:0]      rsum2_q;
   logic [7:0]       ang2_q;
   logic [CBITS-1:0] base2_q;
   logic             v2_q, hs2_q, vs2_q;

   always_comb begin
      dx2    = {10'b0, dx_q} * {10'b0, dx_q};
      dy2    = {10'b0, dy_q} * {10'b0, dy_q};
      r2_sum = {1'b0, dx2} + {1'b0, dy2};
      r2     = r2_sum[20] ? 20'hFFFFF : r2_sum[19:0];
      rsum_d = {1'b0, r2} + 21'(pulse1_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsum2_q <= '0;
         ang2_q  <= '0;
         base2_q <= '0;
         v2_q    <= 1'b0;
         hs2_q   <= 1'b0;
         vs2_q   <= 1'b0;
      end else begin
         rsum2_q <= rsum_d;
         ang2_q  <= ang1_q;
         base2_q <= base1_q;
         v2_q    <= v1_q;
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
      end
   end

   // Stage 3
   logic [20:0]        ring;
   logic [3:0]         idx;
   logic [17:0]        tint_w;
   logic               lit;
   logic [3*CBITS-1:0] rgb_d;
   logic [3*CBITS-1:0] rgb_q;
   logic               hs3_q, vs3_q;

   always_comb begin
      ring   = rsum2_q >> RING_SHIFT;
      idx    = ring[3:0];
      tint_w = TINT[idx];
      lit    = v2_q && (ring < NRINGS) &&
               (ang2_q[ANG_TA[idx]] ^ ang2_q[ANG_TB[idx]]);
      rgb_d  = '0;
      if (lit) begin
         // Channel c=0 is blue (low bits); each channel wraps on its own.
         for (int c = 0; c < 3; c++) begin
            rgb_d[c*CBITS +: CBITS] = tint_w[c*6 + 6 - CBITS +: CBITS] + base2_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rgb_q <= '0;
         hs3_q <= 1'b0;
         vs3_q <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         hs3_q <= hs2_q;
         vs3_q <= vs2_q;
      end
   end

   assign rgb       = rgb_q;
   assign hsync_out = hs3_q;
   assign vsync_out = vs3_q;

endmodule

// File: tb/tb_mandala_pixel_pipe.sv
module tb_mandala_pixel_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       pix_valid = 1'b0;
   logic [9:0] pix_x = '0;
   logic [9:0] pix_y = '0;
   logic       hsync_in = 1'b0;
   logic       vsync_in = 1'b0;
   logic [1:0] mode = '0;
   logic [2:0] speed = '0;
   logic [5:0] rgb;
   logic       hsync_out;
   logic       vsync_out;

   mandala_pixel_pipe dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .mode        (mode),
      .speed       (speed),
      .rgb         (rgb),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Reference tables: angle-bit pairs and 6-bit tint per channel.
   int TA [16] = '{0,1,2,3,4,5,6,7,0,2,4,6,1,3,5,7};
   int TB [16] = '{1,2,3,4,5,6,7,0,3,5,7,1,4,6,0,2};
   int TR [16] = '{63,63,63,0,0,0,32,63,63,16,48,0,16,40,8,40};
   int TG [16] = '{0,32,63,63,63,0,0,0,63,16,16,48,0,40,40,8};
   int TBL[16] = '{0,0,0,0,63,63,63,63,63,16,0,16,48,8,40,40};

   // Model animation state.
   int m_rot = 0, m_col = 0, m_pulse = 0;
   int m_pst = 0; // 0 idle, 1 growing, 2 shrinking

   function automatic int model_pix(input int x, input int y, input bit v,
                                    input bit hs, input bit vs);
      int dx, dy, r2, ring, ang, base, r, g, b, col;
      dx = (x >= 320) ? x - 320 : 320 - x;
      dy = (y >= 240) ? y - 240 : 240 - y;
      r2 = dx*dx + dy*dy;
      if (r2 > 1048575) r2 = 1048575;
      ring = (r2 + m_pulse) / 16384;
      ang  = (((dx % 256) ^ (dy % 256)) + m_rot) % 256;
      col  = 0;
      if (v && ring < 8 && (((ang >> TA[ring]) & 1) != ((ang >> TB[ring]) & 1))) begin
         base = m_col / 64;
         r = (TR[ring]  / 16 + base) % 4;
         g = (TG[ring]  / 16 + base) % 4;
         b = (TBL[ring] / 16 + base) % 4;
         col = r*16 + g*4 + b;
      end
      return col*4 + int'(hs)*2 + int'(vs);
   endfunction

   task automatic model_frame(input int md, input int sp);
      int stp;
      stp = 64 * (sp + 1);
      if (md != 0) m_rot = (m_rot + sp + 1) % 256;
      if (md == 2) m_col = (m_col + sp + 1) % 256;
      if (md != 3) begin
         m_pst = 0;
         m_pulse = 0;
      end else if (m_pst != 2) begin
         m_pulse = m_pulse + stp;
         if (m_pulse >= 8191) begin
            m_pulse = 8191;
            m_pst = 2;
         end else m_pst = 1;
      end else begin
         if (m_pulse <= stp) begin
            m_pulse = 0;
            m_pst = 1;
         end else m_pulse = m_pulse - stp;
      end
   endtask

   typedef struct { int due; int val; } exp_t;
   exp_t sb[$];

   // Drive one cycle of inputs, record what must come out 3 edges later,
   // then advance past the sampling edge.
   task automatic step(input bit rst, input bit fs, input bit v, input int x, input int y,
                       input bit hs, input bit vs, input int md, input int sp);
      int n;
      rst_n = ~rst;
      frame_start = fs;
      pix_valid = v;
      pix_x = 10'(x);
      pix_y = 10'(y);
      hsync_in = hs;
      vsync_in = vs;
      mode = 2'(md);
      speed = 3'(sp);
      n = cyc;
      if (rst) begin
         while (sb.size() > 0 && sb[sb.size()-1].due > n) void'(sb.pop_back());
         for (int k = 1; k <= 3; k++) sb.push_back('{n + k, 0});
         m_rot = 0; m_col = 0; m_pulse = 0; m_pst = 0;
      end else begin
         sb.push_back('{n + 3, model_pix(x, y, v, hs, vs)});
         if (fs) model_frame(md, sp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_cycle(input bit fs, input int md, input int sp);
      int x, y, mdv, spv;
      x   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 639));
      y   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 479));
      mdv = fs ? md : int'($urandom_range(0, 3));
      spv = fs ? sp : int'($urandom_range(0, 7));
      step(1'b0, fs, $urandom_range(0, 7) != 0, x, y,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, mdv, spv);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         chk("stale_expectation", cyc, sb[0].due);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk($sformatf("pix@%0d {rgb,hs,vs}", cyc), int'({rgb, hsync_out, vsync_out}), sb[0].val);
         void'(sb.pop_front());
      end
   end

   initial begin
      // Reset, then directed latency checks in static mode.
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1'b0, 0, 1, 321, 240, 0, 0, 0, 0);  // ring 0, lit
      step(1'b0, 0, 1, 320, 240, 0, 0, 0, 0);  // centre, angle bits equal
      step(1'b0, 0, 1, 639, 479, 0, 0, 0, 0);  // ring 9, black
      step(1'b0, 0, 0, 639, 479, 1, 0, 0, 0);  // hsync pulse
      step(1'b0, 0, 0, 0, 0, 0, 1, 0, 0);      // vsync pulse
      repeat (3) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Mid-frame reset with valid high and syncs toggling.
      for (int i = 0; i < 6; i++) step(1'b0, 0, 1, 321, 240, i[0], ~i[0], 0, 0);
      step(1'b1, 0, 1, 321, 240, 1, 1, 0, 0);
      chk("rst_rgb", int'(rgb), 0);
      chk("rst_hsync", int'(hsync_out), 0);
      chk("rst_vsync", int'(vsync_out), 0);
      step(1'b0, 0, 0, 321, 240, 1, 0, 0, 0);
      step(1'b0, 0, 0, 321, 240, 0, 1, 0, 0);
      repeat (4) step(1'b0, 0, 1, 321, 240, 0, 0, 0, 0);

      // Rotation wrap: mode 1, speed 7, 32 frames; colour counter must not move.
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int f = 0; f < 32; f++) begin
         rnd_cycle(1'b1, 1, 7);
         chk("rot_cnt", int'(dut.u_anim.rot_q), m_rot);
         chk("col_cnt", int'(dut.u_anim.col_q), m_col);
         rnd_cycle(1'b0, 0, 0);
      end
      chk("rot_wrap", int'(dut.u_anim.rot_q), 0);

      // Pulse mode, speed 0: grow to clamp, shrink, then drop back to idle.
      step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int f = 1; f <= 130; f++) begin
         rnd_cycle(1'b1, 3, 0);
         chk($sformatf("pulse_f%0d", f), int'(dut.u_anim.pulse_q), m_pulse);
         if (f == 128) chk("pulse_clamp", int'(dut.u_anim.pulse_q), 8191);
         if (f == 129) chk("pulse_shrink", int'(dut.u_anim.pulse_q), 8127);
         repeat (3) rnd_cycle(1'b0, 0, 0);
      end
      rnd_cycle(1'b1, 0, 0);
      chk("pulse_exit", int'(dut.u_anim.pulse_q), 0);
      rnd_cycle(1'b0, 0, 0);
      rnd_cycle(1'b1, 3, 0);
      chk("pulse_restart", int'(dut.u_anim.pulse_q), 64);

      // Random traffic: all modes/speeds, occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) step(1'b1, 1, 1, 320, 240, 1, 1, 3, 7);
         else rnd_cycle($urandom_range(0, 11) == 0, int'($urandom_range(0, 3)),
                        int'($urandom_range(0, 7)));
      end

      // Blanking inside ring 0.
      for (int i = 0; i < 8; i++) step(1'b0, 0, 0, 321 + i, 240, 0, 0, 0, 0);

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
